// File: rtl/free_list_mp.sv
// ============================================================================
// free_list_mp
// ----------------------------------------------------------------------------
// Multi-port physical-register free list for the rename stage. A circular
// buffer of free register indices hands out up to NUM_DEQ registers per cycle
// (all-or-nothing) and accepts up to NUM_ENQ released registers per cycle.
// A speculative head (r_head) and a retired head (r_rhead) are kept so that a
// mispredict flush returns every register allocated by squashed instructions
// in a single cycle by snapping the speculative head back to the retired one.
//
// Optional integrity checking is enabled with the macro FREE_LIST_CHECK_EN.
// It adds a membership vector and a sticky error flag. Without the macro,
// o_err is tied low and no checking logic exists.
//
// Ports:
//   i_clk          clock, state updates on the rising edge
//   i_rst          asynchronous active-high reset
//   i_deq_req      per-lane allocation request
//   o_deq_ok       every requesting lane is granted this cycle
//   o_deq_preg     register offered to each allocation lane
//   i_enq_valid    per-lane release valid
//   i_enq_preg     released register per lane
//   i_commit_alloc number of committing register-allocating instructions
//   i_flush        mispredict recovery
//   o_count        number of speculatively free entries
//   o_err          sticky integrity error (checked build only)
// ============================================================================
module free_list_mp #(
    parameter int NUM_ENTRIES = 32,
    parameter int PREG_BITS   = 6,
    parameter int NUM_DEQ     = 2,
    parameter int NUM_ENQ     = 2
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_DEQ-1:0]                 i_deq_req,
    output logic                               o_deq_ok,
    output logic [NUM_DEQ*PREG_BITS-1:0]       o_deq_preg,
    input  logic [NUM_ENQ-1:0]                 i_enq_valid,
    input  logic [NUM_ENQ*PREG_BITS-1:0]       i_enq_preg,
    input  logic [$clog2(NUM_ENQ+1)-1:0]       i_commit_alloc,
    input  logic                               i_flush,
    output logic [$clog2(NUM_ENTRIES):0]       o_count,
    output logic                               o_err
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    logic [PREG_BITS-1:0] r_mem [NUM_ENTRIES];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_rhead;
    logic [PTR_W-1:0]     r_tail;

    logic [PTR_W-1:0]     w_count;
    logic [PTR_W-1:0]     w_deqK;
    logic [PTR_W-1:0]     w_rdPtr [NUM_DEQ];
    logic [PREG_BITS-1:0] w_rdData [NUM_DEQ];
    logic [PTR_W-1:0]     w_spare;
    logic [PTR_W-1:0]     w_enqN;
    logic [PTR_W-1:0]     w_wrPtr [NUM_ENQ];
    logic                 w_wrEn [NUM_ENQ];
    logic [PTR_W-1:0]     w_headNext;
    logic [PTR_W-1:0]     w_rheadNext;

    // The wrap bit makes tail - head range over 0..NUM_ENTRIES.
    assign w_count = r_tail - r_head;
    assign o_count = w_count;

    // Each requesting lane takes the next free slot after all lower-numbered
    // requesting lanes. Idle lanes still see the slot they would have taken.
    always_comb begin
        w_deqK     = '0;
        o_deq_preg = '0;
        for (int i = 0; i < NUM_DEQ; i++) begin
            w_rdPtr[i]  = r_head + w_deqK;
            w_rdData[i] = r_mem[w_rdPtr[i][IDX_W-1:0]];
            o_deq_preg[i*PREG_BITS +: PREG_BITS] = w_rdData[i];
            w_deqK = w_deqK + PTR_W'(i_deq_req[i]);
        end
        o_deq_ok = (w_count >= w_deqK) && !i_flush;
    end

    // Released registers are packed in lane order at the tail. Lanes that
    // would push the list beyond its depth are dropped, measured against the
    // registered count so same-cycle allocations are not relied upon.
    always_comb begin
        w_spare = PTR_W'(NUM_ENTRIES) - w_count;
        w_enqN  = '0;
        for (int i = 0; i < NUM_ENQ; i++) begin
            w_wrPtr[i] = r_tail + w_enqN;
            w_wrEn[i]  = 1'b0;
            if (i_enq_valid[i] && (w_enqN < w_spare)) begin
                w_wrEn[i] = 1'b1;
                w_enqN    = w_enqN + 1'b1;
            end
        end
    end

    // The retired head always moves by the commit count; a flush rebases the
    // speculative head on the retired head including this cycle's commits.
    always_comb begin
        w_rheadNext = r_rhead + PTR_W'(i_commit_alloc);
        w_headNext  = r_head;
        if (i_flush) begin
            w_headNext = w_rheadNext;
        end else if (o_deq_ok) begin
            w_headNext = r_head + w_deqK;
        end
    end

    // Storage and pointers. After reset the list holds every register above
    // the 32 architectural ones, so the tail starts one full lap ahead.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mem[i] <= PREG_BITS'(32 + i);
            end
            r_head  <= '0;
            r_rhead <= '0;
            r_tail  <= PTR_W'(NUM_ENTRIES);
        end else begin
            for (int i = 0; i < NUM_ENQ; i++) begin
                if (w_wrEn[i]) begin
                    r_mem[w_wrPtr[i][IDX_W-1:0]] <= i_enq_preg[i*PREG_BITS +: PREG_BITS];
                end
            end
            r_head  <= w_headNext;
            r_rhead <= w_rheadNext;
            r_tail  <= r_tail + w_enqN;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    localparam int NUM_PHYS_REGS = NUM_ENTRIES + 32;

    logic [NUM_PHYS_REGS-1:0] r_member;
    logic                     r_err;
    logic                     w_chkErr;
    logic [PREG_BITS-1:0]     w_pregI;
    logic [PREG_BITS-1:0]     w_pregJ;
    logic [PTR_W-1:0]         w_inflight;

    // Flags double releases, duplicates within one group, dropped releases
    // and a retired head that has run past the speculative head.
    always_comb begin
        w_chkErr   = 1'b0;
        w_pregI    = '0;
        w_pregJ    = '0;
        w_inflight = w_headNext - w_rheadNext;
        if (w_inflight > PTR_W'(NUM_ENTRIES)) begin
            w_chkErr = 1'b1;
        end
        for (int i = 0; i < NUM_ENQ; i++) begin
            w_pregI = i_enq_preg[i*PREG_BITS +: PREG_BITS];
            if (i_enq_valid[i]) begin
                if (!w_wrEn[i] || r_member[w_pregI]) begin
                    w_chkErr = 1'b1;
                end
                for (int j = 0; j < i; j++) begin
                    w_pregJ = i_enq_preg[j*PREG_BITS +: PREG_BITS];
                    if (i_enq_valid[j] && (w_pregJ == w_pregI)) begin
                        w_chkErr = 1'b1;
                    end
                end
            end
        end
    end

    // Membership follows allocations and releases; releases are applied last
    // so a register handed out and returned in the same cycle stays marked.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_member <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_member[32 + i] <= 1'b1;
            end
            r_err <= 1'b0;
        end else begin
            if (o_deq_ok) begin
                for (int i = 0; i < NUM_DEQ; i++) begin
                    if (i_deq_req[i]) begin
                        r_member[w_rdData[i]] <= 1'b0;
                    end
                end
            end
            for (int i = 0; i < NUM_ENQ; i++) begin
                if (w_wrEn[i]) begin
                    r_member[i_enq_preg[i*PREG_BITS +: PREG_BITS]] <= 1'b1;
                end
            end
            r_err <= r_err | w_chkErr;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_mp.sv
// ============================================================================
// tb_free_list_mp
// ----------------------------------------------------------------------------
// Self-checking bench for free_list_mp. The reference model keeps three
// queues of register numbers: the speculatively free list, the allocated but
// not yet retired registers, and retired registers that may be released.
// ============================================================================
module tb_free_list_mp;

    localparam int N  = 32;
    localparam int PB = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    deqReq;
    logic          deqOk;
    logic [2*PB-1:0] deqPreg;
    logic [1:0]    enqValid;
    logic [2*PB-1:0] enqPreg;
    logic [1:0]    commitAlloc;
    logic          flush;
    logic [5:0]    count;
    logic          err;

    int freeQ[$];
    int inflightQ[$];
    int retiredQ[$];
    int errExp;
    int testsRun;
    int testsFailed;

    free_list_mp #(
        .NUM_ENTRIES (N),
        .PREG_BITS   (PB),
        .NUM_DEQ     (2),
        .NUM_ENQ     (2)
    ) dut (
        .i_clk          (clock),
        .i_rst          (reset),
        .i_deq_req      (deqReq),
        .o_deq_ok       (deqOk),
        .o_deq_preg     (deqPreg),
        .i_enq_valid    (enqValid),
        .i_enq_preg     (enqPreg),
        .i_commit_alloc (commitAlloc),
        .i_flush        (flush),
        .o_count        (count),
        .o_err          (err)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reset the DUT and bring the model back to the initial free list 32..63
    task automatic resetDut();
        reset       = 1'b1;
        deqReq      = '0;
        enqValid    = '0;
        enqPreg     = '0;
        commitAlloc = '0;
        flush       = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        freeQ.delete();
        inflightQ.delete();
        retiredQ.delete();
        for (int i = 0; i < N; i++) freeQ.push_back(32 + i);
        errExp = 0;
        #1;
    endtask

    // One cycle: drive inputs, compare the combinational outputs and the
    // registered count against the model, then advance the model and clock
    task automatic applyStimulus(input logic [1:0] deq, input logic [1:0] ev,
                                 input int p0, input int p1, input int ca,
                                 input logic fl);
        int k;
        int idx;
        int cnt0;
        int accepted;
        int pr;
        int lanePreg[2];
        bit okExp;
        @(negedge clock);
        deqReq      = deq;
        enqValid    = ev;
        enqPreg     = {6'(p1), 6'(p0)};
        commitAlloc = 2'(ca);
        flush       = fl;
        #1;
        cnt0  = freeQ.size();
        k     = int'(deq[0]) + int'(deq[1]);
        okExp = (cnt0 >= k) && !fl;
        checkOutput("deq_ok", int'(deqOk), int'(okExp));
        checkOutput("count", int'(count), cnt0);
        checkOutput("err", int'(err), errExp);
        if (okExp) begin
            idx = 0;
            for (int j = 0; j < 2; j++) begin
                if (deq[j]) begin
                    checkOutput($sformatf("deq_preg%0d", j), int'(deqPreg[j*PB +: PB]), freeQ[idx]);
                    idx++;
                end
            end
        end

        for (int c = 0; c < ca; c++) retiredQ.push_back(inflightQ.pop_front());
        if (fl) begin
            while (inflightQ.size() > 0) freeQ.push_front(inflightQ.pop_back());
        end else if (okExp) begin
            for (int c = 0; c < k; c++) inflightQ.push_back(freeQ.pop_front());
        end

        lanePreg[0] = p0;
        lanePreg[1] = p1;
        accepted = 0;
        for (int j = 0; j < 2; j++) begin
            if (ev[j]) begin
                pr = lanePreg[j];
`ifdef FREE_LIST_CHECK_EN
                for (int q = 0; q < cnt0; q++) if (freeQ[q] == pr) errExp = 1;
                if (j == 1 && ev[0] && p0 == p1) errExp = 1;
`endif
                if (accepted < N - cnt0) begin
                    freeQ.push_back(pr);
                    accepted++;
                end else begin
`ifdef FREE_LIST_CHECK_EN
                    errExp = 1;
`endif
                end
            end
        end
        @(posedge clock);
    endtask

    task automatic randomCycle();
        logic [1:0] deq;
        logic [1:0] ev;
        int p0;
        int p1;
        int ca;
        int n;
        int maxN;
        logic fl;
        deq  = 2'($urandom_range(0, 3));
        ca   = $urandom_range(0, inflightQ.size() > 2 ? 2 : inflightQ.size());
        fl   = ($urandom_range(0, 11) == 0);
        maxN = retiredQ.size() > 2 ? 2 : retiredQ.size();
        n    = $urandom_range(0, maxN);
        ev   = 2'b00;
        p0   = 0;
        p1   = 0;
        if (n == 2) begin
            ev = 2'b11;
            p0 = retiredQ.pop_front();
            p1 = retiredQ.pop_front();
        end else if (n == 1) begin
            if ($urandom_range(0, 1) == 1) begin
                ev = 2'b10;
                p1 = retiredQ.pop_front();
            end else begin
                ev = 2'b01;
                p0 = retiredQ.pop_front();
            end
        end
        applyStimulus(deq, ev, p0, p1, ca, fl);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Reset state
        resetDut();
        checkOutput("reset_count", int'(count), 32);
        checkOutput("reset_err", int'(err), 0);

        // Two-lane grant straight out of reset hands out 32 and 33
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
        #1;
        checkOutput("dual_count", int'(count), 30);

        // Only lane 1 requests and receives the head entry
        applyStimulus(2'b10, 2'b00, 0, 0, 0, 1'b0);
        #1;
        checkOutput("lane1_count", int'(count), 29);

        // Drain to one entry, then a two-lane request must be refused
        repeat (14) applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
        #1;
        checkOutput("drain_count", int'(count), 1);
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
        #1;
        checkOutput("refused_count", int'(count), 1);
        applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);
        #1;
        checkOutput("last_count", int'(count), 0);

        // Release register 5 on lane 1 into the empty list, then allocate it
        applyStimulus(2'b00, 2'b10, 0, 5, 0, 1'b0);
        #1;
        checkOutput("rel_count", int'(count), 1);
        checkOutput("rel_preg", int'(deqPreg[0 +: PB]), 5);
        applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);

        // Flush recovery: retire 32..40, squash 41..43
        resetDut();
        repeat (4) applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
        repeat (2) applyStimulus(2'b11, 2'b00, 0, 0, 2, 1'b0);
        repeat (2) applyStimulus(2'b00, 2'b00, 0, 0, 2, 1'b0);
        applyStimulus(2'b00, 2'b00, 0, 0, 1, 1'b0);
        #1;
        checkOutput("preflush_count", int'(count), 20);
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b1);
        #1;
        checkOutput("flush_count", int'(count), 23);
        checkOutput("flush_head", int'(deqPreg[0 +: PB]), 41);
        applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);

        // Release into a full list is an overflow
        resetDut();
        applyStimulus(2'b00, 2'b01, 5, 0, 0, 1'b0);
        #1;
        checkOutput("ovf_count", int'(count), 32);
        applyStimulus(2'b00, 2'b00, 0, 0, 0, 1'b0);

`ifdef FREE_LIST_CHECK_EN
        // Releasing a register that is still free raises a sticky error
        resetDut();
        applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
        applyStimulus(2'b00, 2'b01, 40, 0, 0, 1'b0);
        #1;
        checkOutput("dup_err", int'(err), 1);
        repeat (3) applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);
        resetDut();
        checkOutput("dup_err_cleared", int'(err), 0);
`endif

        // Randomized traffic against the queue model
        resetDut();
        repeat (400) randomCycle();

        // Reset in the middle of traffic restores the initial state
        reset = 1'b1;
        #1;
        checkOutput("midrst_count", int'(count), 32);
        checkOutput("midrst_preg", int'(deqPreg[0 +: PB]), 32);
        resetDut();
        repeat (200) randomCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
